// File: rtl/twos_comp_serial_ctrl_if.sv
// twos_comp_serial_ctrl_if
//   Valid/ready bundle between a word producer, the serial two's complement
//   controller and a result consumer.
//   in_valid/in_ready/in_data    : producer -> controller word handshake
//   out_valid/out_ready/out_data : controller -> consumer result handshake
//   modport slave  : the controller side
//   modport master : the producer/consumer (environment) side
interface twos_comp_serial_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/twos_comp_serial_ctrl.sv
// twos_comp_serial_ctrl
//   Computes the WIDTH+1-bit two's complement {carry, ~a + 1} of a word by
//   stepping one half-adder cell over the operand, LSB first, one bit per
//   clock. IDLE accepts a word, RUN takes WIDTH cycles, DONE holds the
//   result until the consumer takes it.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of twos_comp_serial_ctrl_if (in_* / out_* handshakes)
//   busy : high in RUN or DONE
//   ovf  : only with TWOS_COMP_OVF_EN defined; high in DONE when the operand
//          was the most negative signed value (1 followed by zeros)
// Options
//   TWOS_COMP_OVF_EN : adds the ovf output and its operand detector
module twos_comp_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    twos_comp_serial_ctrl_if.slave bus,
    output logic                   busy
`ifdef TWOS_COMP_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   out_q, out_d;

    logic             bit_n;
    logic             sum;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // The operand register doubles as the result shifter: each sum bit enters
    // at the top while the unconsumed operand bits move down towards bit 0,
    // so after WIDTH shifts it holds the full result. The result is copied to
    // out_q on the last RUN edge so out_data never shows partial values.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        carry_d       = carry_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;

        bit_n = ~op_q[0];
        sum   = bit_n ^ carry_q;
        last  = (cnt_q == CW'(WIDTH - 1));

        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    op_d    = bus.in_data;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                op_d    = {sum, op_q[WIDTH-1:1]};
                carry_d = bit_n & carry_q;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    out_d   = {bit_n & carry_q, sum, op_q[WIDTH-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.out_data = out_q;

`ifdef TWOS_COMP_OVF_EN
    logic ovf_cand_q, ovf_cand_d;

    always_comb begin
        ovf_cand_d = ovf_cand_q;
        if (state_q == IDLE && bus.in_valid) begin
            ovf_cand_d = (bus.in_data == {1'b1, {(WIDTH-1){1'b0}}});
        end else if (state_q == DONE && bus.out_ready) begin
            ovf_cand_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cand_q <= 1'b0;
        end else begin
            ovf_cand_q <= ovf_cand_d;
        end
    end

    assign ovf = ovf_cand_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_twos_comp_serial_ctrl.sv
// tb_twos_comp_serial_ctrl
//   Directed checks of twos_comp_serial_ctrl at WIDTH=8 plus a random
//   valid/ready stream with a scoreboard. Inputs change 1 ns after each
//   rising edge; outputs are read at the same point.
module tb_twos_comp_serial_ctrl;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef TWOS_COMP_OVF_EN
    logic ovf;
`endif

    int vec = 0;
    int err = 0;

    twos_comp_serial_ctrl_if #(.WIDTH(W)) bus ();

    twos_comp_serial_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
`ifdef TWOS_COMP_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one word with out_ready=1. lat counts edges from the accept edge
    // up to the first edge at which out_valid is seen high (1 = next edge).
    task automatic run_word(input logic [W-1:0] a, output logic [W:0] res,
                            output int lat, output logic ovf_seen);
        int n;
        bus.out_ready = 1'b1;
        bus.in_data   = a;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        step();                      // accept edge
        bus.in_valid = 1'b0;
        bus.in_data  = ~a;           // must be ignored from now on
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            step();
            lat++;
        end
        res = bus.out_data;
        ovf_seen = 1'b0;
`ifdef TWOS_COMP_OVF_EN
        ovf_seen = ovf;
`endif
        step();                      // handshake edge
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 9'h000 || busy !== 1'b0) begin
            err++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h busy=%b, need 1 0 000 0",
                     bus.in_ready, bus.out_valid, bus.out_data, busy);
        end
    endtask

    task automatic test_basic();
        logic [W:0] res;
        int         lat;
        logic       o;
        run_word(8'h05, res, lat, o);
        vec++;
        if (lat !== W + 1) begin
            err++;
            $display("FAIL basic_latency: got %0d edges, need %0d", lat, W + 1);
        end
        vec++;
        if (res !== 9'h0FB) begin
            err++;
            $display("FAIL basic_0x05: got %h, need 0fb", res);
        end
        vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            busy !== 1'b0 || bus.out_data !== 9'h0FB) begin
            err++;
            $display("FAIL basic_back_to_idle: in_ready=%b out_valid=%b busy=%b out_data=%h, need 1 0 0 0fb",
                     bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] a   [3] = '{8'h00, 8'h80, 8'hFF};
        logic [W:0]   exp [3] = '{9'h100, 9'h080, 9'h001};
        logic         eovf[3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   res;
        int           lat;
        logic         o;
        for (int i = 0; i < 3; i++) begin
            run_word(a[i], res, lat, o);
            vec++;
            if (res !== exp[i]) begin
                err++;
                $display("FAIL boundary_%h: got %h, need %h", a[i], res, exp[i]);
            end
`ifdef TWOS_COMP_OVF_EN
            vec++;
            if (o !== eovf[i]) begin
                err++;
                $display("FAIL ovf_%h: got %b, need %b", a[i], o, eovf[i]);
            end
            vec++;
            if (ovf !== 1'b0) begin
                err++;
                $display("FAIL ovf_clear_%h: got %b after leaving DONE, need 0", a[i], ovf);
            end
`else
            if (o !== 1'b0 && eovf[i] === 1'b0) begin
                err++;
                $display("FAIL ovf_absent_%h: got %b, need 0", a[i], o);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] res;
        int         lat;
        int         n;
        logic       o;
        bus.out_ready = 1'b0;
        bus.in_data   = 8'h3C;
        bus.in_valid  = 1'b1;
        step();                      // accept
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hA5;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        bus.in_valid = 1'b1;         // second word must not be taken
        bus.in_data  = 8'h77;
        for (int i = 0; i < 20; i++) begin
            vec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 9'h0C4 ||
                bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                err++;
                $display("FAIL hold_cycle%0d: out_valid=%b out_data=%h in_ready=%b busy=%b, need 1 0c4 0 1",
                         i, bus.out_valid, bus.out_data, bus.in_ready, busy);
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            err++;
            $display("FAIL release_idle: in_ready=%b out_valid=%b, need 1 0",
                     bus.in_ready, bus.out_valid);
        end
        run_word(8'h01, res, lat, o);
        vec++;
        if (res !== 9'h0FF || lat !== W + 1) begin
            err++;
            $display("FAIL after_hold_0x01: got %h lat %0d, need 0ff lat %0d", res, lat, W + 1);
        end
    endtask

    task automatic test_abort();
        logic [W:0] res;
        int         lat;
        logic       o;
        bus.out_ready = 1'b1;
        bus.in_data   = 8'h5A;
        bus.in_valid  = 1'b1;
        step();                      // accept
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        bus.in_valid = 1'b1;         // reset must beat anything else
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 9'h000 || busy !== 1'b0) begin
            err++;
            $display("FAIL abort: in_ready=%b out_valid=%b out_data=%h busy=%b, need 1 0 000 0",
                     bus.in_ready, bus.out_valid, bus.out_data, busy);
        end
        for (int i = 0; i < W + 2; i++) begin
            vec++;
            if (bus.out_valid !== 1'b0) begin
                err++;
                $display("FAIL abort_no_output: out_valid=%b at cycle %0d, need 0", bus.out_valid, i);
            end
            step();
        end
        run_word(8'h02, res, lat, o);
        vec++;
        if (res !== 9'h0FE || lat !== W + 1) begin
            err++;
            $display("FAIL after_abort_0x02: got %h lat %0d, need 0fe lat %0d", res, lat, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp_q[$];
        logic [W:0] e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        while (got < 200 && cyc < 20000) begin
            bus.in_valid  = (sent < 200) && ($urandom_range(3) != 0);
            bus.in_data   = W'($urandom);
            bus.out_ready = ($urandom_range(1) == 1);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(9'(9'd256 - {1'b0, bus.in_data}));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                vec++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL stream_extra: out_data=%h with nothing outstanding", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        err++;
                        $display("FAIL stream_word%0d: got %h, need %h", got, bus.out_data, e);
                    end
                end
                got++;
            end
            step();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vec++;
        if (sent != 200 || got != 200 || exp_q.size() != 0) begin
            err++;
            $display("FAIL stream_count: sent %0d received %0d outstanding %0d, need 200 200 0",
                     sent, got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
